// File: rtl/vga_timing_gen.sv
`default_nettype none
// vga_timing_gen: pixel-strobed raster timing (sync, active video, coordinates, line/frame markers).
// Optional macro VGA_TEST_PATTERN_EN adds a 12-bit colour-bar output rgb.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0] rgb
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON      = (SYNC_POL != 0);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       vis_next;
    logic       hsync_next;
    logic       vsync_next;

    // Outputs are derived from the next counts so they land on the same edge as x_pos/y_pos.
    always_comb begin
        h_wrap     = (h_count == H_LAST);
        h_next     = h_wrap ? 10'd0 : h_count + 10'd1;
        v_next     = v_count;
        if (h_wrap) begin
            v_next = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end
        vis_next   = (h_next < H_VIS) && (v_next < V_VIS);
        hsync_next = ((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_next = ((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [9:0]  bar_idx;
    logic [11:0] bar_rgb;

    always_comb begin
        bar_idx = h_next / BAR_W;
        bar_rgb = 12'h000;
        case (bar_idx)
            10'd0:   bar_rgb = 12'hFFF;
            10'd1:   bar_rgb = 12'hFF0;
            10'd2:   bar_rgb = 12'h0FF;
            10'd3:   bar_rgb = 12'h0F0;
            10'd4:   bar_rgb = 12'hF0F;
            10'd5:   bar_rgb = 12'hF00;
            10'd6:   bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb <= 12'h000;
        end else if (pix_en) begin
            rgb <= vis_next ? bar_rgb : 12'h000;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_count     <= h_next;
                v_count     <= v_next;
                hsync       <= hsync_next;
                vsync       <= vsync_next;
                video_on    <= vis_next;
                line_start  <= (h_next == 10'd0);
                frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
                if ((h_next == 10'd0) && (v_next == 10'd0)) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    assign x_pos = h_count;
    assign y_pos = v_count;

    // Totals must fit the 10-bit counters.
    always_ff @(posedge clk) begin
        assert ((H_TOTAL <= 1024) && (V_TOTAL <= 1024))
            else $error("vga_timing_gen: line or frame total exceeds 1024");
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// tb_vga_timing_gen: randomized pixel-strobe stimulus checked against a strobe-count model.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       chk_en = 1'b0;
    logic       seen_wrap = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n = 0;
    logic       strobe_d = 1'b0;

    logic       m_hsync, m_vsync, m_vid, m_ls, m_fs;
    logic [9:0] m_x, m_y;
    logic [7:0] m_fc;
    logic       s_hsync, s_vsync, s_vid, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] m_rgb, s_rgb;
`endif

    always #5 clk = ~clk;

    vga_timing_gen u_main (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .hsync(m_hsync), .vsync(m_vsync), .video_on(m_vid),
        .x_pos(m_x), .y_pos(m_y), .line_start(m_ls), .frame_start(m_fs),
        .frame_count(m_fc)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(m_rgb)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
    ) u_small (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_vid),
        .x_pos(s_x), .y_pos(s_y), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(s_rgb)
`endif
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  fc;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } obs_t;

    // Everything follows from the number of accepted strobes since reset release.
    function automatic obs_t model(input int cnt, input bit sd,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit pol);
        obs_t        o;
        int          ht, vt, ft, h, v;
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        ft = ht * vt;
        if (cnt == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            h = (cnt - 1) % ht;
            v = ((cnt - 1) % ft) / ht;
        end
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.vid = (h < ha) && (v < va);
        o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        o.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        o.fc  = (cnt == 0) ? 8'd0 : 8'((((cnt - 1) / ft) + 1) % 256);
        o.ls  = sd && (cnt > 0) && (h == 0);
        o.fs  = sd && (cnt > 0) && (h == 0) && (v == 0);
        o.rgb = o.vid ? bars[h / (ha / 8)] : 12'h000;
        return o;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n        <= 0;
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= pix_en;
            if (pix_en) n <= n + 1;
        end
    end

    always @(negedge clk) begin : cmp_proc
        obs_t e, g;
        if (chk_en) begin
            e = model(n, strobe_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            g.hs = m_hsync; g.vs = m_vsync; g.vid = m_vid; g.x = m_x; g.y = m_y;
            g.fc = m_fc; g.ls = m_ls; g.fs = m_fs;
`ifdef VGA_TEST_PATTERN_EN
            g.rgb = m_rgb;
`else
            g.rgb = 12'h000; e.rgb = 12'h000;
`endif
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL main_cycle n=%0d got=%h expected=%h", n, g, e);
            end
            e = model(n, strobe_d, 8, 2, 3, 3, 4, 1, 2, 3, 1'b1);
            g.hs = s_hsync; g.vs = s_vsync; g.vid = s_vid; g.x = s_x; g.y = s_y;
            g.fc = s_fc; g.ls = s_ls; g.fs = s_fs;
`ifdef VGA_TEST_PATTERN_EN
            g.rgb = s_rgb;
`else
            g.rgb = 12'h000; e.rgb = 12'h000;
`endif
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL small_cycle n=%0d got=%h expected=%h", n, g, e);
            end
            if (s_fs && s_fc == 8'd0) seen_wrap = 1'b1;
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit en);
        @(negedge clk);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int tx);
        int k;
        k = 0;
        while (m_x != 10'(tx) && k < 2000) begin
            step(1'b1);
            k++;
        end
        if (m_x != 10'(tx)) lit("run_to_timeout", m_x, tx);
    endtask

    task automatic bringup();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0); step(1'b0); step(1'b0);
        lit("pre_strobe_fs", m_fs, 0);
        step(1'b1);
        lit("first_x", m_x, 0);
        lit("first_y", m_y, 0);
        lit("first_fs", m_fs, 1);
        lit("first_ls", m_ls, 1);
        lit("first_fc", m_fc, 1);
        lit("first_vid", m_vid, 1);
        lit("first_hsync", m_hsync, 1);
        step(1'b0);
        lit("fs_drop", m_fs, 0);
        lit("ls_drop", m_ls, 0);
        lit("hold_x", m_x, 0);
        step(1'b0); step(1'b0); step(1'b1);
        lit("fourth_strobe_x", m_x, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        lit("reset_x", m_x, 799);
        lit("reset_y", m_y, 524);
        lit("reset_hsync", m_hsync, 1);
        lit("reset_small_hsync", s_hsync, 0);
        bringup();

        run_to(300);
        repeat (100) step(1'b0);
        lit("pause_x", m_x, 300);
        lit("pause_ls", m_ls, 0);
        step(1'b1);
        lit("resume_x", m_x, 301);

        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            case (m_x)
                10'd639: lit("vid_639", m_vid, 1);
                10'd640: lit("vid_640", m_vid, 0);
                10'd655: lit("hsync_655", m_hsync, 1);
                10'd656: lit("hsync_656", m_hsync, 0);
                10'd751: lit("hsync_751", m_hsync, 0);
                10'd752: lit("hsync_752", m_hsync, 1);
                10'd0:   lit("line2_ls", m_ls, 1);
                default: ;
            endcase
`ifdef VGA_TEST_PATTERN_EN
            case (m_x)
                10'd0:   lit("rgb_0", m_rgb, 12'hFFF);
                10'd80:  lit("rgb_80", m_rgb, 12'hFF0);
                10'd639: lit("rgb_639", m_rgb, 12'h000);
                10'd640: lit("rgb_640", m_rgb, 12'h000);
                default: ;
            endcase
`endif
        end

        repeat (42000) step(1'b1);
        lit("small_fc_wrap_seen", seen_wrap, 1);
        for (int i = 0; i < 8000; i++) step($urandom_range(0, 3) != 0);

        run_to(700);
        lit("pre_reset_hsync", m_hsync, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        lit("async_hsync", m_hsync, 1);
        lit("async_vid", m_vid, 0);
        lit("async_fc", m_fc, 0);
        lit("async_x", m_x, 799);
        lit("async_y", m_y, 524);
        lit("async_ls", m_ls, 0);
        step(1'b0); step(1'b1);
        lit("reset_hold_x", m_x, 799);
        pix_en = 1'b0;
        bringup();
        repeat (4) step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the display path.
- Advances one pixel per pixel-enable strobe; the strobe comes from the clock divider's rising-phase enable, which runs at 25 MHz for the system clock.
- Produces horizontal/vertical sync, an active-video flag, pixel coordinates and frame/line markers for the downstream frame-buffer reader.
- All outputs are registered and stay stable between strobes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
pix_en  in  1  one-clk pixel strobe from the clock divider
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  high while the current pixel is in the visible area
x_pos  out  10  current horizontal count (h_count)
y_pos  out  10  current vertical count (v_count)
line_start  out  1  one-clk pulse when h_count becomes 0
frame_start  out  1  one-clk pulse when (h_count, v_count) becomes (0,0)
frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset (asynchronous on reset_n low):
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1.
  - hsync = vsync = ~SYNC_POL; video_on = 0.
  - line_start = frame_start = 0; frame_count = 0.
- Reset release is synchronous to clk. The first pix_en after release wraps to (0,0) and fires frame_start and line_start.
- Counters change only on a clk edge with pix_en=1:
  - h_count increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_count increments and wraps V_TOTAL-1 -> 0.
- With pix_en=0, counts and all level outputs hold. Pulse outputs return to 0.
- Registered outputs are computed from the new (next) counts on the same edge, so outputs always match x_pos/y_pos with zero skew:
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL.
- Pulse outputs:
  - line_start and frame_start are 1 for exactly one clk (the pix_en edge producing the wrap), then 0 on the next clk regardless of pix_en.
  - frame_count increments on the same edge as frame_start (first frame after reset reads 1).
- Arithmetic:
  - Counters are 10-bit unsigned; comparisons are unsigned.
  - Parameters whose totals exceed 1024 are illegal; a simulation-only assertion flags them.
- pix_en held high continuously is legal: one pixel per clk.
- Reset asserted mid-line: all outputs return to reset values immediately, no partial pulse.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds output rgb (12 bits), registered alongside video_on.
  - While video_on=1, shows 8 vertical colour bars of width H_ACTIVE/8. Bar index = x_pos / (H_ACTIVE/8); colours are white, yellow, cyan, green, magenta, red, blue, black (4 bits per channel, full-on = 4'hF).
  - While video_on=0, rgb = 0.
  - Reset value of rgb is 0.
- Not defined: no rgb port; no pattern logic synthesised.

Test Plan:
- Reset release, then pix_en every 4th clk -> first strobe gives x_pos=0, y_pos=0, frame_start=1 and line_start=1 for one clk, frame_count=1, video_on=1.
- Run one full line -> hsync low exactly for x_pos 656..751 (96 strobes); video_on falls at x_pos=640; line_start recurs every 800 strobes.
- Run one full frame -> vsync low for y_pos 490..491 only; frame_start recurs every 420000 strobes; no video_on for y_pos >= 480.
- pix_en held low for 100 clks mid-line at x_pos=300 -> all outputs frozen, no pulses; resumes at x_pos=301.
- Assert reset_n low at x_pos=700, y_pos=200 (during hsync) -> hsync=1, video_on=0, frame_count=0 in the same cycle without a clk edge; recovery repeats scenario 1.
- With VGA_TEST_PATTERN_EN: x_pos=0 -> rgb=12'hFFF; x_pos=80 -> 12'hFF0; x_pos=639 -> 12'h000; x_pos=640 -> 12'h000 (blanked).
